// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: turns byte/halfword/word accesses into
// word accesses on a 1-cycle synchronous RAM, with read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int Width_B = 32,
    parameter int Addr_B  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_read,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [Addr_B-1:0]  req_addr,
    input  logic [Width_B-1:0] req_wdata,
    output logic               stall,
    output logic               load_valid,
    output logic [Width_B-1:0] load_data,
    output logic               access_fault,
    output logic               mem_read,
    output logic               mem_write,
    output logic [Addr_B-1:0]  mem_addr,
    output logic [Width_B-1:0] mem_wdata,
    input  logic [Width_B-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;

    state_t             state;
    logic [Addr_B-1:0]  cap_addr;
    logic [1:0]         cap_size;
    logic               cap_unsigned;
    logic [15:0]        cap_wdata;

    logic               has_req;
    logic               bad_req;
    logic               accept;
    logic [4:0]         lane_shift;
    logic [Width_B-1:0] shifted;
    logic [Width_B-1:0] extended;
    logic [Width_B-1:0] lane_mask;
    logic [Width_B-1:0] insert;
    logic [Width_B-1:0] merged;

    assign has_req = req_read | req_write;
    assign bad_req = (req_read & req_write)
                   | (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    assign accept  = (state == IDLE) & has_req & ~bad_req & ~reset;

    // Lane alignment for the captured access; a halfword at addr[1]=1 is
    // simply a 16-bit shift, so one shifter serves both sizes.
    assign lane_shift = {cap_addr[1:0], 3'b000};
    assign shifted    = mem_rdata >> lane_shift;
    assign lane_mask  = ((cap_size == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
    assign insert     = {16'h0000, cap_wdata} << lane_shift;
    assign merged     = (mem_rdata & ~lane_mask) | (insert & lane_mask);

    always_comb begin
        case (cap_size)
            2'b00:   extended = cap_unsigned ? {24'h000000, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   extended = cap_unsigned ? {16'h0000, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: extended = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cap_addr     <= '0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_wdata    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_addr     <= req_addr;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_wdata    <= req_wdata[15:0];
                        if (req_read)
                            state <= LOAD_WAIT;
                        else if (req_size != 2'b10)
                            state <= RMW_WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All handshake and RAM outputs are decoded from state and the live request.
    always_comb begin
        stall        = 1'b0;
        load_valid   = 1'b0;
        load_data    = '0;
        access_fault = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (has_req && bad_req) begin
                        access_fault = 1'b1;
                    end else if (has_req) begin
                        mem_addr = {2'b00, req_addr[Addr_B-1:2]};
                        if (req_write && req_size == 2'b10) begin
                            mem_write = 1'b1;
                            mem_wdata = req_wdata;
                        end else begin
                            mem_read = 1'b1;
                            stall    = 1'b1;
                        end
                    end
                end
                LOAD_WAIT: begin
                    load_valid = 1'b1;
                    load_data  = extended;
                end
                RMW_WRITE: begin
                    mem_write = 1'b1;
                    mem_addr  = {2'b00, cap_addr[Addr_B-1:2]};
                    mem_wdata = merged;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan followed by random
// traffic, checked against a byte-addressed reference memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        access_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] ram [0:255];
    logic [31:0] initWords [0:255];
    logic [7:0]  refMem [0:1023];
    logic        ramInit;
    logic [7:0]  ramIdx;
    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .access_fault(access_fault), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Word-wide synchronous RAM with one cycle of read latency.
    assign ramIdx = 8'(mem_addr % 32'd256);
    always @(posedge clk) begin
        if (ramInit) begin
            for (int i = 0; i < 256; i++) ram[i] <= initWords[i];
        end else begin
            if (mem_write) ram[ramIdx] <= mem_wdata;
            if (mem_read) mem_rdata <= ram[ramIdx];
        end
    end

    function automatic logic [31:0] modelWord(input int idx);
        return {refMem[4*idx+3], refMem[4*idx+2], refMem[4*idx+1], refMem[4*idx]};
    endfunction

    function automatic logic [31:0] modelLoad(input int a, input logic [1:0] size, input logic uns);
        int v;
        if (size == 2'b00) begin
            v = int'(refMem[a]);
            if (!uns && v >= 128) v -= 256;
            return 32'(v);
        end else if (size == 2'b01) begin
            v = int'(refMem[a]) + 256 * int'(refMem[a+1]);
            if (!uns && v >= 32768) v -= 65536;
            return 32'(v);
        end
        return {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
    endfunction

    task automatic modelStore(input int a, input logic [1:0] size, input logic [31:0] data);
        int n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) refMem[a+i] = 8'(data >> (8*i));
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clearReq();
        req_read = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    // One complete access; expected behaviour derived from the access rules and the model.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic isFault;
        int   a;
        int   idx;
        logic [31:0] expLoad;
        isFault = (rd && wr) || size == 2'b11 || (size == 2'b01 && addr[0])
                  || (size == 2'b10 && addr[1:0] != 2'b00);
        a   = int'(addr);
        idx = a / 4;
        req_read = rd; req_write = wr; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        checkOutput("cyc0_fault", 32'(access_fault), 32'(isFault));
        checkOutput("cyc0_both", 32'(mem_read & mem_write), 32'h0);
        checkOutput("cyc0_lvalid", 32'(load_valid), 32'h0);
        checkOutput("cyc0_ldata", load_data, 32'h0);
        if (isFault) begin
            checkOutput("fault_strobe", 32'(mem_read | mem_write), 32'h0);
            checkOutput("fault_stall", 32'(stall), 32'h0);
            checkOutput("fault_addr", mem_addr, 32'h0);
            @(posedge clk); #1;
            checkOutput("fault_ram", ram[idx], modelWord(idx));
        end else if (rd) begin
            expLoad = modelLoad(a, size, uns);
            checkOutput("ld_read", 32'(mem_read), 32'h1);
            checkOutput("ld_stall", 32'(stall), 32'h1);
            checkOutput("ld_addr", mem_addr, 32'(idx));
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("ld_valid", 32'(load_valid), 32'h1);
            checkOutput("ld_data", load_data, expLoad);
            checkOutput("ld_stall1", 32'(stall), 32'h0);
            checkOutput("ld_strobe1", 32'(mem_read | mem_write), 32'h0);
            @(posedge clk); #1;
        end else if (size == 2'b10) begin
            checkOutput("sw_write", 32'(mem_write), 32'h1);
            checkOutput("sw_read", 32'(mem_read), 32'h0);
            checkOutput("sw_stall", 32'(stall), 32'h0);
            checkOutput("sw_addr", mem_addr, 32'(idx));
            checkOutput("sw_wdata", mem_wdata, wdata);
            modelStore(a, size, wdata);
            @(posedge clk); #1;
            checkOutput("sw_ram", ram[idx], modelWord(idx));
        end else begin
            checkOutput("rmw_read", 32'(mem_read), 32'h1);
            checkOutput("rmw_write0", 32'(mem_write), 32'h0);
            checkOutput("rmw_stall0", 32'(stall), 32'h1);
            checkOutput("rmw_addr0", mem_addr, 32'(idx));
            modelStore(a, size, wdata);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("rmw_write1", 32'(mem_write), 32'h1);
            checkOutput("rmw_read1", 32'(mem_read), 32'h0);
            checkOutput("rmw_stall1", 32'(stall), 32'h0);
            checkOutput("rmw_addr1", mem_addr, 32'(idx));
            checkOutput("rmw_wdata", mem_wdata, modelWord(idx));
            @(posedge clk); #1;
            checkOutput("rmw_ram", ram[idx], modelWord(idx));
        end
        clearReq();
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_stall"}, 32'(stall), 32'h0);
        checkOutput({tag, "_lvalid"}, 32'(load_valid), 32'h0);
        checkOutput({tag, "_strobe"}, 32'(mem_read | mem_write), 32'h0);
        checkOutput({tag, "_fault"}, 32'(access_fault), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startCycle;
        logic rd, wr, uns;
        logic [1:0] size;
        logic [31:0] addr;
        for (int i = 0; i < 256; i++) begin
            initWords[i] = $urandom;
            for (int b = 0; b < 4; b++) refMem[4*i+b] = 8'(initWords[i] >> (8*b));
        end
        ramInit = 1'b1;
        reset = 1'b1;
        clearReq();
        req_read = 1'b1;
        req_addr = 32'h10;
        @(posedge clk); #1;
        @(negedge clk);
        checkQuiet("reset");
        checkOutput("reset_addr", mem_addr, 32'h0);
        checkOutput("reset_ldata", load_data, 32'h0);
        @(posedge clk); #1;
        ramInit = 1'b0;
        reset = 1'b0;
        clearReq();
        @(negedge clk);
        checkQuiet("idle");
        @(posedge clk); #1;

        $display("[TB] word store then word load");
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        $display("[TB] sub-word loads");
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80F17F01);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h22, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);

        $display("[TB] read-modify-write");
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h23, 32'h000000AB);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h0000CAFE);

        $display("[TB] faults");
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h55AA55AA);

        $display("[TB] reset during RMW_WRITE");
        req_write = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h77;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkQuiet("rst_rmw");
        @(posedge clk); #1;
        reset = 1'b0;
        clearReq();
        checkOutput("rst_rmw_ram", ram[8], modelWord(8));
        @(negedge clk);
        checkQuiet("rst_rmw_idle");
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

        $display("[TB] reset during LOAD_WAIT");
        req_read = 1'b1; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkQuiet("rst_ld");
        checkOutput("rst_ld_data", load_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        clearReq();

        $display("[TB] back-to-back traffic");
        startCycle = cycleCount;
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h0000005A);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5F00D);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h31, 32'h0);
        checkOutput("b2b_cycles", 32'(cycleCount - startCycle), 32'd7);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:             begin rd = 1'b1; wr = 1'b1; end
                1, 2, 3, 4:    begin rd = 1'b1; wr = 1'b0; end
                default:       begin rd = 1'b0; wr = 1'b1; end
            endcase
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) != 0) begin
                if (size == 2'b01) addr[0] = 1'b0;
                if (size == 2'b10) addr[1:0] = 2'b00;
            end
            applyStimulus(rd, wr, size, uns, addr, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store controller between the EX/MEM pipeline register and the word-wide data memory block. It accepts byte, halfword and word loads and stores at byte addresses, converts them to word accesses on the 1-cycle-latency synchronous RAM port, and performs read-modify-write for sub-word stores. It returns aligned and sign/zero-extended load data, and it stalls the pipeline while a multi-cycle access is in flight.

## Interface
- Width_B, 32, data width; only 32 is supported.
- Addr_B, 32, byte-address width.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_read  in  1  load request from EX/MEM.
- req_write  in  1  store request from EX/MEM.
- req_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  selects zero-extension for loads; 0 selects sign-extension.
- req_addr  in  Addr_B  byte address.
- req_wdata  in  Width_B  store data, right-justified.
- stall  out  1  holds EX/MEM and earlier stages.
- load_valid  out  1  load_data valid this cycle.
- load_data  out  Width_B  extended load result.
- access_fault  out  1  one-cycle pulse for a rejected request.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe; never asserted together with mem_read.
- mem_addr  out  Addr_B  word index, {2'b00, addr[Addr_B-1:2]}.
- mem_wdata  out  Width_B  RAM write data.
- mem_rdata  in  Width_B  RAM read data, valid one cycle after mem_read.

## Operation
- The unit uses a little-endian layout:
  - Byte lane k is bits [8k+7:8k], selected by addr[1:0] = k.
  - The halfword at addr[1] = 0 is bits [15:0]; at addr[1] = 1 it is bits [31:16].
- Requests are sampled only in IDLE. They are captured into internal registers (address, size, unsigned flag, write data) on acceptance.
- A request is rejected when any of these hold:
  - req_read and req_write are both high.
  - req_size = 11.
  - A halfword access has addr[0] = 1.
  - A word access has addr[1:0] != 0.
- On rejection: access_fault = 1 for that cycle, no RAM strobe, stall = 0, state stays IDLE.
- The state machine has three states: IDLE, LOAD_WAIT, RMW_WRITE.
  - IDLE, valid load: drive mem_read = 1 and mem_addr from req_addr. Set stall = 1. Next state is LOAD_WAIT.
  - IDLE, valid word store: drive mem_write = 1, mem_addr, and mem_wdata = req_wdata. Set stall = 0. Stay in IDLE.
  - IDLE, valid byte or halfword store: drive mem_read = 1 and mem_addr. Set stall = 1. Next state is RMW_WRITE.
  - LOAD_WAIT: extract the selected lane from mem_rdata using the captured addr[1:0] and size, then extend it. Set load_valid = 1 and stall = 0. Next state is IDLE.
  - RMW_WRITE: form merged = mem_rdata with the addressed lane(s) replaced by the low 8 or 16 bits of the captured wdata. Drive mem_write = 1, mem_wdata = merged, and mem_addr from the captured address. Set stall = 0. Next state is IDLE.
- Extension rules:
  - Byte load: sign-extend from bit 7, or zero-extend when unsigned.
  - Halfword load: sign-extend from bit 15, or zero-extend when unsigned.
  - Word load: passed through unchanged.
- When no strobe is active, mem_addr and mem_wdata are 0. Likewise load_data is 0 whenever load_valid = 0.
- No requests are accepted outside IDLE. Upstream holds the request stable while stall = 1, and the unit ignores it during that time.

## Timing
- Reset values: state IDLE. stall, load_valid, load_data, access_fault, mem_read, mem_write, mem_addr and mem_wdata are all 0. Outputs are forced to 0 in any cycle where reset is high.
- Load: 2 cycles. Stall in cycle 0; load_valid in cycle 1.
- Word store: 1 cycle, no stall. The write commits at the end of cycle 0.
- Sub-word store: 2 cycles. Read in cycle 0 with stall; write in cycle 1 without stall. The merged word commits at the end of cycle 1.
- A new request can be accepted in the cycle after LOAD_WAIT or RMW_WRITE. Back-to-back accesses have no dead cycle.
- Reset during LOAD_WAIT: no load_valid.
- Reset during RMW_WRITE: the pending write is abandoned, mem_write = 0, and RAM is unchanged.
- The state is IDLE in the cycle after reset deasserts.
- stall, load_valid, access_fault and the mem_* outputs are decoded combinationally from the state and the request. Only the state and the captured request are registered.

## Test plan
- Word store then word load:
  - Stimulus: store 0xDEADBEEF to 0x10, then load 0x10.
  - Response: mem_write with mem_addr = 4 and no stall; the load stalls 1 cycle, then load_valid with load_data = 0xDEADBEEF.
- Byte loads from word 0x80F17F01 at 0x20:
  - Signed load of 0x22 gives 0xFFFFFFF1; unsigned gives 0x000000F1.
  - Signed load of 0x21 gives 0x0000007F.
  - Signed halfword load of 0x22 gives 0xFFFF80F1.
- Read-modify-write:
  - Byte store of 0xAB to 0x23 over 0x11223344 leaves RAM at 0xAB223344.
  - Halfword store of 0xCAFE to 0x20 over 0x11223344 leaves RAM at 0x1122CAFE.
  - Both cases: stall for exactly 1 cycle, and mem_read and mem_write are never simultaneously high.
- Faults: each of the following pulses access_fault for 1 cycle, with no strobe, no stall and RAM unchanged:
  - Halfword load at 0x21.
  - Word store at 0x12.
  - req_size = 11.
  - req_read and req_write both high.
- Reset mid-access: assert reset in the RMW_WRITE cycle of a byte store to 0x20. Response: no mem_write, RAM word unchanged, IDLE next cycle, and a subsequent load works normally.
- Back-to-back traffic: load, sub-word store, word store, load on consecutive accepted cycles. Response: total cycles = 2 + 2 + 1 + 2 = 7, and results match a reference memory model.
